// File: rtl/tc1_monitor.sv
// Polls the Pmod TC1 interface, runs a moving-average filter over good samples
// and raises an over-temperature alarm with hysteresis; flags sensor faults.
module tc1_monitor #(
    parameter int POLL_PERIOD  = 10_000_000,
    parameter int AVG_LOG2     = 2,
    parameter int HYST         = 8,
    parameter int BUSY_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        tc_update_all,
    input  logic        tc_busy,
    input  logic [13:0] tc_temperature,
    input  logic [11:0] tc_internal,
    input  logic [2:0]  tc_status,
    input  logic        tc_fault,
    input  logic [13:0] threshold_high,
    output logic [13:0] avg_temp,
    output logic [11:0] last_internal,
    output logic        avg_valid,
    output logic        sample_strobe,
    output logic        alarm_over,
    output logic        sensor_fault,
    output logic [2:0]  fault_code
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 14 + AVG_LOG2;
    localparam int TW    = $clog2(POLL_PERIOD);
    localparam int BW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FW    = AVG_LOG2 + 1;
    localparam logic [TW-1:0] PERIOD_M1  = TW'(POLL_PERIOD - 1);
    localparam logic [BW-1:0] TIMEOUT_M1 = BW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_BUSY, S_SETTLE, S_PROC} state_t;

    state_t               state_reg;
    logic [TW-1:0]        timer_reg;
    logic [BW-1:0]        bto_reg;
    logic                 update_all_reg;
    logic [PW-1:0]        wr_ptr_reg;
    logic [FW-1:0]        fill_reg;
    logic signed [SW-1:0] sum_reg;
    logic [13:0]          avg_temp_reg;
    logic [11:0]          last_internal_reg;
    logic                 avg_valid_reg;
    logic                 sample_strobe_reg;
    logic                 alarm_reg;
    logic                 sensor_fault_reg;
    logic [2:0]           fault_code_reg;
    logic                 avg_upd_reg;
    logic                 alarm_eval_reg;
    logic [13:0]          oldest_reg;
    logic [13:0]          ring_mem [DEPTH];

    logic                 take_sample;
    logic                 full;
    logic signed [SW-1:0] new_ext;
    logic signed [SW-1:0] old_ext;
    logic signed [SW-1:0] sum_next;
    logic signed [14:0]   avg15;
    logic signed [14:0]   thr15;
    logic signed [14:0]   clr15;

    assign take_sample = (state_reg == S_PROC) && !tc_fault;
    assign full        = (fill_reg == FW'(DEPTH));
    assign new_ext     = SW'($signed(tc_temperature));
    // Slots never written since reset count as zero; while filling, the write
    // pointer always lands on such a slot, so no RAM clear is needed.
    assign old_ext     = full ? SW'($signed(oldest_reg)) : '0;
    assign sum_next    = sum_reg + new_ext - old_ext;

    assign avg15 = 15'($signed(avg_temp_reg));
    assign thr15 = 15'($signed(threshold_high));
    assign clr15 = thr15 - 15'(HYST);

    // Ring buffer with registered read; the oldest entry is pre-fetched while
    // the pointer sits still during the transfer.
    always_ff @(posedge clk) begin
        if (take_sample) begin
            ring_mem[wr_ptr_reg] <= tc_temperature;
        end
        oldest_reg <= ring_mem[wr_ptr_reg];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= S_IDLE;
            timer_reg         <= '0;
            bto_reg           <= '0;
            update_all_reg    <= 1'b0;
            wr_ptr_reg        <= '0;
            fill_reg          <= '0;
            sum_reg           <= '0;
            avg_temp_reg      <= '0;
            last_internal_reg <= '0;
            avg_valid_reg     <= 1'b0;
            sample_strobe_reg <= 1'b0;
            alarm_reg         <= 1'b0;
            sensor_fault_reg  <= 1'b0;
            fault_code_reg    <= '0;
            avg_upd_reg       <= 1'b0;
            alarm_eval_reg    <= 1'b0;
        end else begin
            sample_strobe_reg <= 1'b0;
            avg_upd_reg       <= 1'b0;
            alarm_eval_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (enable) begin
                        state_reg <= S_WAIT;
                        timer_reg <= PERIOD_M1;
                    end
                end
                S_WAIT: begin
                    if (!enable) begin
                        state_reg <= S_IDLE;
                    end else if (timer_reg == '0) begin
                        state_reg      <= S_REQ;
                        update_all_reg <= 1'b1;
                        bto_reg        <= '0;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                S_REQ: begin
                    if (tc_busy) begin
                        update_all_reg <= 1'b0;
                        state_reg      <= S_BUSY;
                    end else if (bto_reg == TIMEOUT_M1) begin
                        update_all_reg   <= 1'b0;
                        sensor_fault_reg <= 1'b1;
                        fault_code_reg   <= 3'b000;
                        state_reg        <= S_WAIT;
                        timer_reg        <= PERIOD_M1;
                    end else begin
                        bto_reg <= bto_reg + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!tc_busy) state_reg <= S_SETTLE;
                end
                S_SETTLE: state_reg <= S_PROC;
                S_PROC: begin
                    if (tc_fault) begin
                        sensor_fault_reg <= 1'b1;
                        fault_code_reg   <= tc_status;
                    end else begin
                        sensor_fault_reg  <= 1'b0;
                        last_internal_reg <= tc_internal;
                        sum_reg           <= sum_next;
                        wr_ptr_reg        <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
                        if (!full) fill_reg <= fill_reg + 1'b1;
                        if (fill_reg == FW'(DEPTH - 1)) avg_valid_reg <= 1'b1;
                        sample_strobe_reg <= 1'b1;
                        avg_upd_reg       <= 1'b1;
                    end
                    if (enable) begin
                        state_reg <= S_WAIT;
                        timer_reg <= PERIOD_M1;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // Average lags the sum by one cycle, the alarm lags the average by one.
            if (avg_upd_reg) begin
                avg_temp_reg   <= 14'(sum_reg >>> AVG_LOG2);
                alarm_eval_reg <= 1'b1;
            end
            if (alarm_eval_reg && avg_valid_reg) begin
                if (avg15 >= thr15)     alarm_reg <= 1'b1;
                else if (avg15 < clr15) alarm_reg <= 1'b0;
            end
        end
    end

    assign tc_update_all = update_all_reg;
    assign avg_temp      = avg_temp_reg;
    assign last_internal = last_internal_reg;
    assign avg_valid     = avg_valid_reg;
    assign sample_strobe = sample_strobe_reg;
    assign alarm_over    = alarm_reg;
    assign sensor_fault  = sensor_fault_reg;
    assign fault_code    = fault_code_reg;
endmodule

// File: tb/tb_tc1_monitor.sv
// Bench for tc1_monitor: a TC1 responder model drives the busy handshake and a
// queue-based moving-average/alarm model predicts every observable result.
module tb_tc1_monitor;
    localparam int POLL_PERIOD  = 20;
    localparam int AVG_LOG2     = 2;
    localparam int HYST         = 8;
    localparam int BUSY_TIMEOUT = 16;
    localparam int DEPTH        = 4;
    localparam int BUSY_LEN     = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        tc_update_all;
    logic        tc_busy = 1'b0;
    logic [13:0] tc_temperature = '0;
    logic [11:0] tc_internal = '0;
    logic [2:0]  tc_status = '0;
    logic        tc_fault = 1'b0;
    logic [13:0] threshold_high = 14'd1000;
    logic [13:0] avg_temp;
    logic [11:0] last_internal;
    logic        avg_valid;
    logic        sample_strobe;
    logic        alarm_over;
    logic        sensor_fault;
    logic [2:0]  fault_code;

    always #5 clk = ~clk;

    tc1_monitor #(
        .POLL_PERIOD(POLL_PERIOD), .AVG_LOG2(AVG_LOG2),
        .HYST(HYST), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .tc_update_all(tc_update_all),
        .tc_busy(tc_busy), .tc_temperature(tc_temperature), .tc_internal(tc_internal),
        .tc_status(tc_status), .tc_fault(tc_fault), .threshold_high(threshold_high),
        .avg_temp(avg_temp), .last_internal(last_internal), .avg_valid(avg_valid),
        .sample_strobe(sample_strobe), .alarm_over(alarm_over),
        .sensor_fault(sensor_fault), .fault_code(fault_code)
    );

    int checks = 0;
    int errors = 0;

    // TC1 responder: answers a held request with BUSY_LEN cycles of busy and
    // presents the prepared result as busy falls.
    logic [13:0] rsp_temp = '0;
    logic [11:0] rsp_int = '0;
    logic        rsp_fault = 1'b0;
    logic [2:0]  rsp_status = '0;
    bit          respond = 1'b1;
    int          xfer_cnt = 0;
    int          strobe_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (tc_update_all === 1'b1 && respond && rst === 1'b1) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                tc_busy = 1'b1;
                repeat (BUSY_LEN) @(negedge clk);
                tc_temperature = rsp_temp;
                tc_internal    = rsp_int;
                tc_fault       = rsp_fault;
                tc_status      = rsp_status;
                tc_busy        = 1'b0;
                xfer_cnt++;
            end
        end
    end

    always @(negedge clk) if (sample_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

    // Reference model: last DEPTH good samples, floor average, hysteretic alarm.
    int win[$];
    int m_avg = 0, m_thr = 1000, m_code = 0, m_int = 0;
    bit m_valid = 0, m_alarm = 0, m_fault = 0;

    function automatic int floor_div(int s, int d);
        int q = s / d;
        if ((s % d != 0) && (s < 0)) q--;
        return q;
    endfunction

    function automatic void model_reset();
        win.delete();
        m_avg = 0; m_code = 0; m_int = 0;
        m_valid = 0; m_alarm = 0; m_fault = 0;
    endfunction

    function automatic void model_sample(int t);
        int s = 0;
        win.push_back(t);
        if (win.size() > DEPTH) void'(win.pop_front());
        foreach (win[i]) s += win[i];
        m_avg = floor_div(s, DEPTH);
        if (win.size() == DEPTH) m_valid = 1;
        if (m_valid) begin
            if (m_avg >= m_thr) m_alarm = 1;
            else if (m_avg < m_thr - HYST) m_alarm = 0;
        end
    endfunction

    task automatic run_poll(input int temp, input int internal, input bit fault,
                            input int status, output int strobes, output bit ok);
        int n0, s0, k;
        rsp_temp = 14'(temp); rsp_int = 12'(internal);
        rsp_fault = fault;    rsp_status = 3'(status);
        n0 = xfer_cnt; s0 = strobe_cnt; k = 0;
        while (xfer_cnt == n0 && k < 400) begin @(negedge clk); k++; end
        ok = (xfer_cnt != n0);
        checks++;
        if (!ok) begin errors++; $display("FAIL poll_complete: no transfer in 400 cycles, need 1"); end
        repeat (8) @(negedge clk);
        strobes = strobe_cnt - s0;
        if (ok) begin
            if (fault) begin m_fault = 1; m_code = status; end
            else begin m_fault = 0; m_int = internal; model_sample(temp); end
        end
        $display("poll temp=%0d fault=%0b -> avg=%0d valid=%0b alarm=%0b sfault=%0b code=%0d strobes=%0d",
                 temp, fault, $signed(avg_temp), avg_valid, alarm_over, sensor_fault, fault_code, strobes);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (tc_update_all !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b need 0", tc_update_all); end
        checks++; if ({avg_temp, last_internal, avg_valid, sample_strobe, alarm_over, sensor_fault, fault_code} !== '0) begin
            errors++; $display("FAIL reset_outputs: got avg=%0d int=%0d valid=%0b strobe=%0b alarm=%0b fault=%0b code=%0d need all 0",
                avg_temp, last_internal, avg_valid, sample_strobe, alarm_over, sensor_fault, fault_code);
        end
        model_reset();
        enable = 1'b1;
        rst = 1'b1;
    endtask

    task automatic test_fill();
        int temps[4] = '{100, 104, 108, 112};
        int st; bit ok;
        foreach (temps[i]) begin
            run_poll(temps[i], 300 + i, 1'b0, 0, st, ok);
            checks++; if ($signed(avg_temp) !== m_avg) begin errors++; $display("FAIL fill_avg: got %0d need %0d", $signed(avg_temp), m_avg); end
            checks++; if (avg_valid !== m_valid) begin errors++; $display("FAIL fill_valid: got %0b need %0b", avg_valid, m_valid); end
            checks++; if (st !== 1) begin errors++; $display("FAIL fill_strobe: got %0d pulses need 1", st); end
            checks++; if (last_internal !== 12'(m_int)) begin errors++; $display("FAIL fill_internal: got %0d need %0d", last_internal, m_int); end
        end
    endtask

    task automatic test_negative();
        int temps[4] = '{-8, -7, -7, -7};
        int st; bit ok;
        foreach (temps[i]) run_poll(temps[i], 5, 1'b0, 0, st, ok);
        checks++; if ($signed(avg_temp) !== m_avg) begin errors++; $display("FAIL neg_avg: got %0d need %0d", $signed(avg_temp), m_avg); end
        checks++; if (avg_valid !== 1'b1) begin errors++; $display("FAIL neg_valid: got %0b need 1", avg_valid); end
    endtask

    task automatic test_alarm();
        int targets[5] = '{399, 400, 393, 392, 391};
        int st, s; bit ok;
        threshold_high = 14'd400; m_thr = 400;
        foreach (targets[i]) begin
            s = 0;
            foreach (win[j]) s += win[j];
            s = DEPTH * targets[i] - (s - win[0]);
            run_poll(s, 9, 1'b0, 0, st, ok);
            checks++; if ($signed(avg_temp) !== m_avg) begin errors++; $display("FAIL alarm_avg: got %0d need %0d", $signed(avg_temp), m_avg); end
            checks++; if (alarm_over !== m_alarm) begin errors++; $display("FAIL alarm_state: avg %0d got %0b need %0b", m_avg, alarm_over, m_alarm); end
        end
    endtask

    task automatic test_fault();
        int st; bit ok;
        run_poll(1234, 77, 1'b1, 1, st, ok);
        checks++; if (sensor_fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %0b need 1", sensor_fault); end
        checks++; if (fault_code !== 3'b001) begin errors++; $display("FAIL fault_code: got %0b need 001", fault_code); end
        checks++; if (st !== 0) begin errors++; $display("FAIL fault_strobe: got %0d pulses need 0", st); end
        checks++; if ($signed(avg_temp) !== m_avg) begin errors++; $display("FAIL fault_avg: got %0d need %0d", $signed(avg_temp), m_avg); end
        checks++; if (last_internal !== 12'(m_int)) begin errors++; $display("FAIL fault_internal: got %0d need %0d", last_internal, m_int); end
        run_poll(380, 11, 1'b0, 0, st, ok);
        checks++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %0b need 0", sensor_fault); end
        checks++; if (st !== 1) begin errors++; $display("FAIL fault_recover_strobe: got %0d pulses need 1", st); end
        checks++; if (alarm_over !== m_alarm) begin errors++; $display("FAIL fault_alarm: got %0b need %0b", alarm_over, m_alarm); end
    endtask

    task automatic test_timeout();
        int k = 0, hi = 0, lo = 0, st; bit ok;
        respond = 1'b0;
        while (tc_update_all !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        while (tc_update_all === 1'b1 && hi < 100) begin @(negedge clk); hi++; end
        respond = 1'b1;
        checks++; if (hi !== BUSY_TIMEOUT) begin errors++; $display("FAIL timeout_req_len: got %0d cycles need %0d", hi, BUSY_TIMEOUT); end
        checks++; if (sensor_fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %0b need 1", sensor_fault); end
        checks++; if (fault_code !== 3'b000) begin errors++; $display("FAIL timeout_code: got %0b need 000", fault_code); end
        m_fault = 1; m_code = 0;
        while (tc_update_all !== 1'b1 && lo < 100) begin @(negedge clk); lo++; end
        checks++; if (lo !== POLL_PERIOD) begin errors++; $display("FAIL timeout_repoll: got %0d cycles need %0d", lo, POLL_PERIOD); end
        run_poll(390, 12, 1'b0, 0, st, ok);
        checks++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL timeout_recover: got %0b need 0", sensor_fault); end
        checks++; if (fault_code !== 3'(m_code)) begin errors++; $display("FAIL timeout_code_hold: got %0b need %0b", fault_code, m_code); end
    endtask

    task automatic test_random();
        int st, t, thr; bit ok, f;
        thr = int'($urandom_range(0, 600)) - 300;
        threshold_high = 14'(thr); m_thr = thr;
        for (int i = 0; i < 12; i++) begin
            t = int'($urandom_range(0, 1600)) - 800;
            f = ($urandom_range(0, 4) == 0);
            run_poll(t, int'($urandom_range(0, 4095)), f, int'($urandom_range(1, 7)), st, ok);
            checks++; if ($signed(avg_temp) !== m_avg) begin errors++; $display("FAIL rand_avg: got %0d need %0d", $signed(avg_temp), m_avg); end
            checks++; if (alarm_over !== m_alarm) begin errors++; $display("FAIL rand_alarm: got %0b need %0b", alarm_over, m_alarm); end
            checks++; if (sensor_fault !== m_fault || fault_code !== 3'(m_code)) begin
                errors++; $display("FAIL rand_fault: got %0b/%0d need %0b/%0d", sensor_fault, fault_code, m_fault, m_code); end
            checks++; if (st !== (f ? 0 : 1)) begin errors++; $display("FAIL rand_strobe: got %0d need %0d", st, f ? 0 : 1); end
            checks++; if (last_internal !== 12'(m_int)) begin errors++; $display("FAIL rand_internal: got %0d need %0d", last_internal, m_int); end
        end
    endtask

    task automatic test_enable();
        int n0, req = 0, st; bit ok;
        enable = 1'b0;
        n0 = xfer_cnt;
        for (int i = 0; i < 150; i++) begin @(negedge clk); if (tc_update_all === 1'b1) req++; end
        checks++; if (req !== 0 || xfer_cnt !== n0) begin errors++; $display("FAIL enable_park: got %0d request cycles need 0", req); end
        enable = 1'b1;
        run_poll(50, 3, 1'b0, 0, st, ok);
        checks++; if (st !== 1) begin errors++; $display("FAIL enable_resume: got %0d pulses need 1", st); end
    endtask

    task automatic test_reset_busy();
        int k = 0, n0, st; bit ok;
        while (tc_busy !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        n0 = xfer_cnt;
        rst = 1'b0;
        #1;
        checks++; if (tc_update_all !== 1'b0) begin errors++; $display("FAIL rstbusy_req: got %0b need 0", tc_update_all); end
        checks++; if ({avg_temp, last_internal, avg_valid, alarm_over, sensor_fault, fault_code} !== '0) begin
            errors++; $display("FAIL rstbusy_outputs: got avg=%0d valid=%0b alarm=%0b fault=%0b need all 0",
                avg_temp, avg_valid, alarm_over, sensor_fault); end
        k = 0;
        while (xfer_cnt == n0 && k < 200) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        model_reset();
        rst = 1'b1;
        k = 0;
        while (tc_update_all !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        // One IDLE cycle, then a full WAIT period.
        checks++; if (k !== POLL_PERIOD + 1) begin errors++; $display("FAIL rstbusy_first_req: got %0d cycles need %0d", k, POLL_PERIOD + 1); end
        for (int i = 0; i < DEPTH; i++) begin
            run_poll(200 + 8 * i, 20, 1'b0, 0, st, ok);
            checks++; if (avg_valid !== m_valid) begin errors++; $display("FAIL rstbusy_valid: got %0b need %0b", avg_valid, m_valid); end
            checks++; if ($signed(avg_temp) !== m_avg) begin errors++; $display("FAIL rstbusy_avg: got %0d need %0d", $signed(avg_temp), m_avg); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_negative();
        test_alarm();
        test_fault();
        test_timeout();
        test_random();
        test_enable();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
